// File: rtl/pc_branch_unit.sv
// Fetch-control stage: program counter, latched ALU flags, branch resolution
// and the start/halt/done run handshake.
module pc_branch_unit #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic             halt,
  input  logic [3:0]       op,
  input  logic             flag_we,
  input  logic             co_in,
  input  logic             z_in,
  input  logic             neg_in,
  input  logic [OFF_W-1:0] target,
  output logic [PC_W-1:0]  pc,
  output logic             ci_out,
  output logic             z_flag,
  output logic             n_flag,
  output logic             br_taken,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [3:0] kCLR = 4'h1;
  localparam logic [3:0] kJMP = 4'hC;
  localparam logic [3:0] kBRZ = 4'hD;
  localparam logic [3:0] kBRN = 4'hE;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             brTaken_q, brTaken_d;
  logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;

  logic [PC_W-1:0]  relTarget;
  logic [PC_W-1:0]  absTarget;

  // Relative branches sign-extend the offset; jumps zero-extend it.
  assign relTarget = pc_q + PC_W'($signed(target));
  assign absTarget = PC_W'(target);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    brTaken_d  = 1'b0;
    cycleCnt_d = cycleCnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          pc_d       = '0;
          carry_d    = 1'b0;
          zero_d     = 1'b0;
          neg_d      = 1'b0;
          cycleCnt_d = '0;
        end
      end

      RUN: begin
        if (halt) begin
          state_d = HALTED;
        end else begin
          if (cycleCnt_q != '1) begin
            cycleCnt_d = cycleCnt_q + 1'b1;
          end

          // Branch decisions look at the flags latched before this edge.
          if (op == kJMP) begin
            pc_d      = absTarget;
            brTaken_d = 1'b1;
          end else if ((op == kBRZ && zero_q) || (op == kBRN && neg_q)) begin
            pc_d      = relTarget;
            brTaken_d = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end

          if (op == kCLR) begin
            carry_d = 1'b0;
            zero_d  = 1'b0;
            neg_d   = 1'b0;
          end else if (flag_we) begin
            carry_d = co_in;
            zero_d  = z_in;
            neg_d   = neg_in;
          end
        end
      end

      HALTED: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      brTaken_q  <= 1'b0;
      cycleCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      brTaken_q  <= brTaken_d;
      cycleCnt_q <= cycleCnt_d;
    end
  end

  assign pc        = pc_q;
  assign ci_out    = carry_q;
  assign z_flag    = zero_q;
  assign n_flag    = neg_q;
  assign br_taken  = brTaken_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == HALTED);
  assign cycle_cnt = cycleCnt_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Randomised and directed bench for pc_branch_unit, checked against an
// integer-arithmetic model of the fetch-control rules.
module tb_pc_branch_unit;

  localparam int PW = 10;
  localparam int OW = 8;
  localparam int CW = 6;
  localparam int PMOD = 1 << PW;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [3:0] kNOP = 4'h0;
  localparam logic [3:0] kCLR = 4'h1;
  localparam logic [3:0] kJMP = 4'hC;
  localparam logic [3:0] kBRZ = 4'hD;
  localparam logic [3:0] kBRN = 4'hE;

  logic          CLK = 1'b0;
  logic          Reset, start, halt, flag_we, co_in, z_in, neg_in;
  logic [3:0]    op;
  logic [OW-1:0] target;
  logic [PW-1:0] pc;
  logic          ci_out, z_flag, n_flag, br_taken, busy, done;
  logic [CW-1:0] cycle_cnt;

  int total = 0;
  int bad = 0;

  // Model state: 0 = idle, 1 = running, 2 = halted.
  int mState, mPc, mCnt;
  bit mC, mZ, mN, mBr;

  pc_branch_unit #(.PC_W(PW), .OFF_W(OW), .CNT_W(CW)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .halt(halt), .op(op),
    .flag_we(flag_we), .co_in(co_in), .z_in(z_in), .neg_in(neg_in),
    .target(target), .pc(pc), .ci_out(ci_out), .z_flag(z_flag),
    .n_flag(n_flag), .br_taken(br_taken), .busy(busy), .done(done),
    .cycle_cnt(cycle_cnt)
  );

  always #5 CLK = ~CLK;

  wire [PW+CW+5:0] dutVec = {pc, ci_out, z_flag, n_flag, br_taken, busy, done, cycle_cnt};

  function automatic logic [PW+CW+5:0] expVec();
    return {PW'(mPc), mC, mZ, mN, mBr, (mState == 1), (mState == 2), CW'(mCnt)};
  endfunction

  // Drives one cycle of inputs, advances the model across the edge, and
  // leaves time 1 unit past the edge so outputs are settled.
  task automatic tick(input logic rst, input logic st, input logic hl,
                      input logic [3:0] o, input logic fw, input logic c,
                      input logic z, input logic n, input logic [OW-1:0] t);
    int off;
    Reset = rst; start = st; halt = hl; op = o;
    flag_we = fw; co_in = c; z_in = z; neg_in = n; target = t;
    @(posedge CLK);
    off = (int'(t) >= (1 << (OW - 1))) ? int'(t) - (1 << OW) : int'(t);
    if (rst) begin
      mState = 0; mPc = 0; mC = 0; mZ = 0; mN = 0; mBr = 0; mCnt = 0;
    end else if (mState == 0) begin
      mBr = 0;
      if (st) begin
        mState = 1; mPc = 0; mC = 0; mZ = 0; mN = 0; mCnt = 0;
      end
    end else if (mState == 1) begin
      if (hl) begin
        mState = 2; mBr = 0;
      end else begin
        if (mCnt < CMAX) mCnt = mCnt + 1;
        if (o == kJMP) begin
          mPc = int'(t); mBr = 1;
        end else if ((o == kBRZ && mZ) || (o == kBRN && mN)) begin
          mPc = ((mPc + off) % PMOD + PMOD) % PMOD; mBr = 1;
        end else begin
          mPc = (mPc + 1) % PMOD; mBr = 0;
        end
        if (o == kCLR) begin
          mC = 0; mZ = 0; mN = 0;
        end else if (fw) begin
          mC = c; mZ = z; mN = n;
        end
      end
    end else begin
      mState = 0; mBr = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, kNOP, 0, 0, 0, 0, 8'h00);
    tick(1, 1, 1, kJMP, 1, 1, 1, 1, 8'h55);
    total++;
    if (dutVec !== expVec()) begin
      bad++; $display("[TB] FAIL reset_state got=%h exp=%h", dutVec, expVec());
    end
    total++;
    if ({pc, busy, done, cycle_cnt} !== '0) begin
      bad++; $display("[TB] FAIL reset_zero got pc=%h busy=%b done=%b cnt=%0d", pc, busy, done, cycle_cnt);
    end
  endtask

  task automatic test_sequential();
    tick(0, 1, 0, kNOP, 0, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 5; i++) begin
      tick(0, 0, 0, kNOP, 0, 0, 0, 0, 8'h00);
      total++;
      if (dutVec !== expVec()) begin
        bad++; $display("[TB] FAIL seq_step%0d got=%h exp=%h", i, dutVec, expVec());
      end
    end
    total++;
    if (pc !== 10'd5 || busy !== 1'b1 || cycle_cnt !== 6'd5) begin
      bad++; $display("[TB] FAIL seq_final got pc=%0d busy=%b cnt=%0d exp pc=5 busy=1 cnt=5", pc, busy, cycle_cnt);
    end
  endtask

  task automatic test_brz();
    tick(0, 0, 0, kJMP, 0, 0, 0, 0, 8'd19);
    tick(0, 0, 0, kNOP, 1, 0, 1, 0, 8'h00);
    tick(0, 0, 0, kBRZ, 0, 0, 0, 0, 8'hFC);
    total++;
    if (pc !== 10'd16 || br_taken !== 1'b1 || dutVec !== expVec()) begin
      bad++; $display("[TB] FAIL brz_taken got pc=%0d br=%b exp pc=16 br=1", pc, br_taken);
    end
    tick(0, 0, 0, kJMP, 1, 0, 0, 0, 8'd20);
    tick(0, 0, 0, kBRZ, 0, 0, 0, 0, 8'hFC);
    total++;
    if (pc !== 10'd21 || br_taken !== 1'b0 || dutVec !== expVec()) begin
      bad++; $display("[TB] FAIL brz_not_taken got pc=%0d br=%b exp pc=21 br=0", pc, br_taken);
    end
  endtask

  task automatic test_clr_and_old_flag();
    tick(0, 0, 0, kNOP, 1, 1, 1, 1, 8'h00);
    total++;
    if ({ci_out, z_flag, n_flag} !== 3'b111) begin
      bad++; $display("[TB] FAIL flag_load got=%b exp=111", {ci_out, z_flag, n_flag});
    end
    tick(0, 0, 0, kCLR, 1, 1, 1, 1, 8'h00);
    total++;
    if ({ci_out, z_flag, n_flag} !== 3'b000 || dutVec !== expVec()) begin
      bad++; $display("[TB] FAIL clr_override got=%b exp=000", {ci_out, z_flag, n_flag});
    end
    tick(0, 0, 0, kNOP, 1, 0, 0, 1, 8'h00);
    tick(0, 0, 0, kBRN, 1, 0, 0, 0, 8'h03);
    total++;
    if (br_taken !== 1'b1 || n_flag !== 1'b0 || dutVec !== expVec()) begin
      bad++; $display("[TB] FAIL brn_old_flag got=%h exp=%h", dutVec, expVec());
    end
  endtask

  task automatic test_wrap();
    tick(0, 0, 0, kJMP, 1, 0, 0, 1, 8'd1);
    tick(0, 0, 0, kBRN, 0, 0, 0, 0, 8'hFD);
    total++;
    if (pc !== 10'h3FE) begin
      bad++; $display("[TB] FAIL wrap_setup got pc=%h exp=3fe", pc);
    end
    tick(0, 0, 0, kBRN, 0, 0, 0, 0, 8'h05);
    total++;
    if (pc !== 10'h003 || dutVec !== expVec()) begin
      bad++; $display("[TB] FAIL wrap_brn got pc=%h exp=003", pc);
    end
    tick(0, 0, 0, kJMP, 0, 0, 0, 0, 8'hA0);
    total++;
    if (pc !== 10'h0A0 || br_taken !== 1'b1) begin
      bad++; $display("[TB] FAIL jmp_abs got pc=%h br=%b exp pc=0a0 br=1", pc, br_taken);
    end
    tick(0, 0, 0, kBRN, 0, 0, 0, 0, 8'h00);
    total++;
    if (pc !== 10'h0A0 || br_taken !== 1'b1) begin
      bad++; $display("[TB] FAIL spin_loop got pc=%h br=%b exp pc=0a0 br=1", pc, br_taken);
    end
    tick(0, 0, 0, kJMP, 0, 0, 0, 0, 8'hFF);
    for (int i = 0; i < 768; i++) tick(0, 0, 0, kNOP, 0, 0, 0, 0, 8'h00);
    total++;
    if (pc !== 10'h3FF) begin
      bad++; $display("[TB] FAIL pc_top got pc=%h exp=3ff", pc);
    end
    tick(0, 0, 0, kNOP, 0, 0, 0, 0, 8'h00);
    total++;
    if (pc !== 10'h000 || cycle_cnt !== 6'd63) begin
      bad++; $display("[TB] FAIL pc_wrap_sat got pc=%h cnt=%0d exp pc=000 cnt=63", pc, cycle_cnt);
    end
  endtask

  task automatic test_halt();
    tick(0, 0, 0, kJMP, 1, 1, 0, 1, 8'd37);
    tick(0, 0, 1, kJMP, 1, 0, 1, 0, 8'h55);
    total++;
    if (pc !== 10'd37 || done !== 1'b1 || busy !== 1'b0 || dutVec !== expVec()) begin
      bad++; $display("[TB] FAIL halt_done got pc=%0d done=%b busy=%b exp pc=37 done=1 busy=0", pc, done, busy);
    end
    tick(0, 0, 1, kNOP, 0, 0, 0, 0, 8'h00);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || pc !== 10'd37 || dutVec !== expVec()) begin
      bad++; $display("[TB] FAIL halt_idle got pc=%0d done=%b busy=%b", pc, done, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    tick(0, 1, 0, kNOP, 0, 0, 0, 0, 8'h00);
    tick(0, 0, 0, kJMP, 1, 1, 1, 1, 8'd12);
    tick(1, 0, 1, kNOP, 0, 0, 0, 0, 8'h00);
    total++;
    if ({pc, ci_out, z_flag, n_flag, busy, done} !== '0 || dutVec !== expVec()) begin
      bad++; $display("[TB] FAIL reset_mid_run got=%h exp=%h", dutVec, expVec());
    end
    tick(0, 0, 0, kNOP, 0, 0, 0, 0, 8'h00);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_no_done got done=%b exp=0", done);
    end
  endtask

  task automatic test_random();
    logic [3:0] o;
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 5))
        0: o = kJMP;
        1: o = kBRZ;
        2: o = kBRN;
        3: o = kCLR;
        default: o = 4'($urandom);
      endcase
      tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 39) == 0), o, 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 8'($urandom));
      total++;
      if (dutVec !== expVec()) begin
        bad++; $display("[TB] FAIL random_cycle%0d got=%h exp=%h", i, dutVec, expVec());
      end
    end
  endtask

  initial begin
    mState = 0; mPc = 0; mCnt = 0; mC = 0; mZ = 0; mN = 0; mBr = 0;
    Reset = 1'b1; start = 0; halt = 0; op = kNOP;
    flag_we = 0; co_in = 0; z_in = 0; neg_in = 0; target = '0;
    test_reset();
    test_sequential();
    test_brz();
    test_clr_and_old_flag();
    test_wrap();
    test_halt();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
